// File: rtl/uart_rx_cfg_ctrl.sv
// Configuration sequencer for the UART RX path: applies prescale/parity changes only
// when the line and RX FSM are quiescent, holding the RX FSM idle during the update.
module uart_rx_cfg_ctrl #(
    parameter int unsigned GUARD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned RESET_PRESCALE = 8,
    parameter bit          RESET_PAR_EN   = 1'b0,
    parameter bit          RESET_PAR_TYPE = 1'b0
) (
    input  logic       clk,
    input  logic       asy_reset,
    input  logic       cfg_req,
    input  logic [5:0] cfg_prescale,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_type,
    input  logic [2:0] rx_state,
    input  logic       RX_IN,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic       cfg_busy,
    output logic       rx_hold,
    output logic [5:0] prescale,
    output logic       parity_enable,
    output logic       parity_type
);

    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0]  RX_IDLE = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_APPLY,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] guard_q, guard_d, guard_inc;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [SW-1:0] settle_q, settle_d;
    logic [5:0]    sh_prescale_q, sh_prescale_d;
    logic          sh_par_en_q, sh_par_en_d;
    logic          sh_par_type_q, sh_par_type_d;
    logic          ack_d, err_d, busy_d, hold_d;
    logic [5:0]    prescale_d;
    logic          par_en_d, par_type_d;
    logic          line_quiet;
    logic          req_legal;
    logic          guard_hit;
    logic          tmo_hit;

    // Saturating increments so no counter ever wraps
    assign guard_inc  = (guard_q == GW'(GUARD_CYCLES)) ? guard_q : guard_q + GW'(1);
    assign tmo_inc    = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
    assign line_quiet = (rx_state == RX_IDLE) && RX_IN;
    assign req_legal  = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) ||
                        (cfg_prescale == 6'd32);
    assign guard_hit  = line_quiet && (guard_inc == GW'(GUARD_CYCLES));
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_inc == TW'(TIMEOUT_CYCLES));

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        guard_d       = guard_q;
        tmo_d         = tmo_q;
        settle_d      = settle_q;
        sh_prescale_d = sh_prescale_q;
        sh_par_en_d   = sh_par_en_q;
        sh_par_type_d = sh_par_type_q;
        ack_d         = cfg_ack;
        err_d         = cfg_err;
        hold_d        = rx_hold;
        prescale_d    = prescale;
        par_en_d      = parity_enable;
        par_type_d    = parity_type;

        case (state_q)
            S_IDLE: begin
                if (cfg_req) begin
                    sh_prescale_d = cfg_prescale;
                    sh_par_en_d   = cfg_parity_en;
                    sh_par_type_d = cfg_parity_type;
                    if (req_legal) begin
                        state_d = S_WAIT;
                        guard_d = '0;
                        tmo_d   = '0;
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                tmo_d   = tmo_inc;
                guard_d = line_quiet ? guard_inc : '0;
                // A qualifying guard beats a simultaneous timeout
                if (guard_hit) begin
                    state_d  = S_HOLD;
                    hold_d   = 1'b1;
                    settle_d = '0;
                end else if (tmo_hit) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_HOLD: begin
                if (rx_state != RX_IDLE) begin
                    state_d = S_WAIT;
                    hold_d  = 1'b0;
                    guard_d = '0;
                end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_APPLY;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_APPLY: begin
                prescale_d = sh_prescale_q;
                par_en_d   = sh_par_en_q;
                par_type_d = sh_par_type_q;
                state_d    = S_ACK;
                hold_d     = 1'b0;
                ack_d      = 1'b1;
                err_d      = 1'b0;
            end
            S_ACK: begin
                if (!cfg_req) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
                ack_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge asy_reset) begin
        if (!asy_reset) begin
            state_q       <= S_IDLE;
            guard_q       <= '0;
            tmo_q         <= '0;
            settle_q      <= '0;
            sh_prescale_q <= 6'(RESET_PRESCALE);
            sh_par_en_q   <= RESET_PAR_EN;
            sh_par_type_q <= RESET_PAR_TYPE;
            cfg_ack       <= 1'b0;
            cfg_err       <= 1'b0;
            cfg_busy      <= 1'b0;
            rx_hold       <= 1'b0;
            prescale      <= 6'(RESET_PRESCALE);
            parity_enable <= RESET_PAR_EN;
            parity_type   <= RESET_PAR_TYPE;
        end else begin
            state_q       <= state_d;
            guard_q       <= guard_d;
            tmo_q         <= tmo_d;
            settle_q      <= settle_d;
            sh_prescale_q <= sh_prescale_d;
            sh_par_en_q   <= sh_par_en_d;
            sh_par_type_q <= sh_par_type_d;
            cfg_ack       <= ack_d;
            cfg_err       <= err_d;
            cfg_busy      <= busy_d;
            rx_hold       <= hold_d;
            prescale      <= prescale_d;
            parity_enable <= par_en_d;
            parity_type   <= par_type_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg_ctrl.sv
// Directed bench for uart_rx_cfg_ctrl: latency, reject, guard restart, hold race,
// timeout and mid-operation reset.
module tb_uart_rx_cfg_ctrl;

    logic       clk;
    logic       asy_reset;
    logic       cfg_req;
    logic [5:0] cfg_prescale;
    logic       cfg_parity_en;
    logic       cfg_parity_type;
    logic [2:0] rx_state;
    logic       RX_IN;
    logic       cfg_ack;
    logic       cfg_err;
    logic       cfg_busy;
    logic       rx_hold;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;

    int checks   = 0;
    int failures = 0;

    uart_rx_cfg_ctrl #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk            (clk),
        .asy_reset      (asy_reset),
        .cfg_req        (cfg_req),
        .cfg_prescale   (cfg_prescale),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_type(cfg_parity_type),
        .rx_state       (rx_state),
        .RX_IN          (RX_IN),
        .cfg_ack        (cfg_ack),
        .cfg_err        (cfg_err),
        .cfg_busy       (cfg_busy),
        .rx_hold        (rx_hold),
        .prescale       (prescale),
        .parity_enable  (parity_enable),
        .parity_type    (parity_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until cfg_ack, and how many of those cycles showed rx_hold
    task automatic wait_ack(output int n, output int hold_n);
        n = 0;
        hold_n = 0;
        while (!cfg_ack && n < 200) begin
            step(1);
            n++;
            if (rx_hold) hold_n++;
        end
        if (!cfg_ack) check_eq("ack_bound", 32'(cfg_ack), 32'd1);
    endtask

    task automatic request(input logic [5:0] ps, input logic pe, input logic pt);
        cfg_prescale    = ps;
        cfg_parity_en   = pe;
        cfg_parity_type = pt;
        cfg_req         = 1'b1;
    endtask

    task automatic release_req(input string tag);
        cfg_req = 1'b0;
        step(1);
        check_eq({tag, "_ack_drop"}, 32'(cfg_ack), 32'd0);
        check_eq({tag, "_err_drop"}, 32'(cfg_err), 32'd0);
        check_eq({tag, "_busy_drop"}, 32'(cfg_busy), 32'd0);
    endtask

    initial begin
        int n;
        int hn;

        asy_reset       = 1'b0;
        cfg_req         = 1'b0;
        cfg_prescale    = 6'd8;
        cfg_parity_en   = 1'b0;
        cfg_parity_type = 1'b0;
        rx_state        = 3'b000;
        RX_IN           = 1'b1;
        step(2);
        check_eq("rst_ack", 32'(cfg_ack), 32'd0);
        check_eq("rst_err", 32'(cfg_err), 32'd0);
        check_eq("rst_busy", 32'(cfg_busy), 32'd0);
        check_eq("rst_hold", 32'(rx_hold), 32'd0);
        check_eq("rst_prescale", 32'(prescale), 32'd8);
        check_eq("rst_par_en", 32'(parity_enable), 32'd0);
        check_eq("rst_par_type", 32'(parity_type), 32'd0);
        asy_reset = 1'b1;
        step(2);

        // Illegal prescale is rejected on the next edge
        request(6'd12, 1'b1, 1'b1);
        wait_ack(n, hn);
        check_eq("ill_latency", 32'(n), 32'd1);
        check_eq("ill_err", 32'(cfg_err), 32'd1);
        check_eq("ill_prescale", 32'(prescale), 32'd8);
        check_eq("ill_par_en", 32'(parity_enable), 32'd0);
        check_eq("ill_hold_cycles", 32'(hn), 32'd0);
        release_req("ill");

        // Uncontested legal request; input changes after acceptance are ignored
        request(6'd16, 1'b1, 1'b0);
        step(1);
        check_eq("t1_busy", 32'(cfg_busy), 32'd1);
        cfg_prescale  = 6'd32;
        cfg_parity_en = 1'b0;
        wait_ack(n, hn);
        check_eq("t1_latency", 32'(n + 1), 32'd22);
        check_eq("t1_hold_cycles", 32'(hn), 32'd5);
        check_eq("t1_err", 32'(cfg_err), 32'd0);
        check_eq("t1_hold_at_ack", 32'(rx_hold), 32'd0);
        check_eq("t1_prescale", 32'(prescale), 32'd16);
        check_eq("t1_par_en", 32'(parity_enable), 32'd1);
        step(3);
        check_eq("t1_ack_held", 32'(cfg_ack), 32'd1);
        release_req("t1");

        // One low cycle on RX_IN at guard=10 restarts the guard
        request(6'd32, 1'b0, 1'b1);
        step(11);
        RX_IN = 1'b0;
        step(1);
        RX_IN = 1'b1;
        wait_ack(n, hn);
        check_eq("t3_latency", 32'(n + 12), 32'd33);
        check_eq("t3_err", 32'(cfg_err), 32'd0);
        check_eq("t3_prescale", 32'(prescale), 32'd32);
        check_eq("t3_par_type", 32'(parity_type), 32'd1);
        release_req("t3");

        // Start detected in the second hold cycle
        request(6'd8, 1'b1, 1'b1);
        step(18);
        check_eq("t4_hold_on", 32'(rx_hold), 32'd1);
        rx_state = 3'b001;
        step(1);
        rx_state = 3'b000;
        check_eq("t4_hold_drop", 32'(rx_hold), 32'd0);
        check_eq("t4_busy", 32'(cfg_busy), 32'd1);
        check_eq("t4_not_applied", 32'(prescale), 32'd32);
        wait_ack(n, hn);
        check_eq("t4_latency", 32'(n + 19), 32'd40);
        check_eq("t4_hold_cycles", 32'(hn), 32'd5);
        check_eq("t4_err", 32'(cfg_err), 32'd0);
        check_eq("t4_prescale", 32'(prescale), 32'd8);
        check_eq("t4_par_en", 32'(parity_enable), 32'd1);
        release_req("t4");

        // RX never idle: timeout abort
        rx_state = 3'b010;
        request(6'd16, 1'b0, 1'b0);
        wait_ack(n, hn);
        check_eq("t5_latency", 32'(n), 32'd101);
        check_eq("t5_err", 32'(cfg_err), 32'd1);
        check_eq("t5_hold_cycles", 32'(hn), 32'd0);
        check_eq("t5_prescale", 32'(prescale), 32'd8);
        check_eq("t5_par_type", 32'(parity_type), 32'd1);
        release_req("t5");
        rx_state = 3'b000;

        // Reset while holding; request stays high across reset
        request(6'd16, 1'b0, 1'b0);
        step(18);
        check_eq("t6_hold_on", 32'(rx_hold), 32'd1);
        asy_reset = 1'b0;
        #1;
        check_eq("t6_hold_async", 32'(rx_hold), 32'd0);
        check_eq("t6_busy_async", 32'(cfg_busy), 32'd0);
        check_eq("t6_prescale_async", 32'(prescale), 32'd8);
        check_eq("t6_par_en_async", 32'(parity_enable), 32'd0);
        check_eq("t6_par_type_async", 32'(parity_type), 32'd0);
        step(2);
        asy_reset = 1'b1;
        wait_ack(n, hn);
        check_eq("t6_latency", 32'(n), 32'd22);
        check_eq("t6_err", 32'(cfg_err), 32'd0);
        check_eq("t6_prescale", 32'(prescale), 32'd16);
        release_req("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
